dequant_8b_16b: RTL and testbench



---
 rtl/npu_quant_pkg.sv | 18 +
 rtl/dequant_lane.sv | 41 ++++
 rtl/dequant_8b_16b.sv | 128 ++++++++++++
 tb/tb_dequant_8b_16b.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_quant_pkg.sv
// Shared quantization constants and types for the NPU int8/int16 datapath.
package npu_quant_pkg;

   localparam logic signed [7:0]  INT8_MIN  = 8'sh80;
   localparam logic signed [7:0]  INT8_MAX  = 8'sh7F;
   localparam logic signed [15:0] INT16_MIN = 16'sh8000;
   localparam logic signed [15:0] INT16_MAX = 16'sh7FFF;

   localparam int unsigned SHIFT_W_DEF = 4;

   typedef logic signed [15:0] int16_t;

   typedef enum logic {
      StEmpty,
      StHold
   } deq_state_e;

endpackage

// File: rtl/dequant_lane.sv
// Single-lane int8 -> int16 expansion: sign-extend, optional zero-point, left shift, saturate.
// Zero-point subtraction is present only when DEQUANT_ZERO_POINT_EN is defined.
module dequant_lane
   import npu_quant_pkg::*;
#(
   parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
   input  logic signed [7:0]   i_lane,
`ifdef DEQUANT_ZERO_POINT_EN
   input  logic signed [7:0]   i_zero_point,
`endif
   input  logic                i_shift_en,
   input  logic [SHIFT_W-1:0]  i_shift_num,
   output int16_t              o_result
);

   // One spare bit over the int8 range covers the 9-bit zero-point difference.
   localparam int unsigned EXT_W = 9 + (1 << SHIFT_W);

   logic signed [8:0]       base;
   logic signed [EXT_W-1:0] ext;
   logic signed [EXT_W-1:0] shifted;

   always_comb begin
`ifdef DEQUANT_ZERO_POINT_EN
      base = 9'(i_lane) - 9'(i_zero_point);
`else
      base = 9'(i_lane);
`endif
      ext     = EXT_W'(base);
      shifted = i_shift_en ? (ext <<< i_shift_num) : ext;
      if (shifted > EXT_W'(INT16_MAX)) begin
         o_result = INT16_MAX;
      end else if (shifted < EXT_W'(INT16_MIN)) begin
         o_result = INT16_MIN;
      end else begin
         o_result = shifted[15:0];
      end
   end

endmodule

// File: rtl/dequant_8b_16b.sv
// Expands a packed int8 word into LANES_IN/LANES_OUT beats of shifted, saturated int16 lanes.
// Optional build macro: DEQUANT_ZERO_POINT_EN adds a per-word zero point.
module dequant_8b_16b
   import npu_quant_pkg::*;
#(
   parameter int unsigned LANES_IN  = 4,
   parameter int unsigned LANES_OUT = 2,
   parameter int unsigned SHIFT_W   = SHIFT_W_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   output logic                   o_in_ready,
   input  logic [8*LANES_IN-1:0]  i_data,
   input  logic                   i_shift_en,
   input  logic [SHIFT_W-1:0]     i_shift_num,
`ifdef DEQUANT_ZERO_POINT_EN
   input  logic signed [7:0]      i_zero_point,
`endif
   output logic                   o_valid,
   input  logic                   i_out_ready,
   output logic [16*LANES_OUT-1:0] o_data,
   output logic                   o_last
);

   localparam int unsigned NBEATS = LANES_IN / LANES_OUT;
   localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic             ONE_BEAT = (NBEATS == 1);

   deq_state_e              state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    valid_q;
   logic                    last_q;
   logic [8*LANES_IN-1:0]   hold_data_q;
   logic                    hold_shift_en_q;
   logic [SHIFT_W-1:0]      hold_shift_num_q;
`ifdef DEQUANT_ZERO_POINT_EN
   logic signed [7:0]       hold_zp_q;
`endif

   logic accept;
   logic xfer;

   assign o_in_ready = !valid_q || (last_q && i_out_ready);
   assign accept     = i_valid && o_in_ready;
   assign xfer       = valid_q && i_out_ready;
   assign o_valid    = valid_q;
   assign o_last     = last_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q          <= StEmpty;
         cnt_q            <= '0;
         valid_q          <= 1'b0;
         last_q           <= 1'b0;
         hold_data_q      <= '0;
         hold_shift_en_q  <= 1'b0;
         hold_shift_num_q <= '0;
`ifdef DEQUANT_ZERO_POINT_EN
         hold_zp_q        <= '0;
`endif
      end else begin
         // accept is only possible when empty or on the last-beat transfer, so the
         // holding register can load unconditionally on it.
         if (accept) begin
            hold_data_q      <= i_data;
            hold_shift_en_q  <= i_shift_en;
            hold_shift_num_q <= i_shift_num;
`ifdef DEQUANT_ZERO_POINT_EN
            hold_zp_q        <= i_zero_point;
`endif
         end
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_q <= StHold;
                  valid_q <= 1'b1;
                  cnt_q   <= '0;
                  last_q  <= ONE_BEAT;
               end
            end
            StHold: begin
               if (xfer) begin
                  if (!last_q) begin
                     cnt_q  <= cnt_q + CNT_ONE;
                     last_q <= ((cnt_q + CNT_ONE) == LAST_CNT);
                  end else if (accept) begin
                     cnt_q  <= '0;
                     last_q <= ONE_BEAT;
                  end else begin
                     state_q <= StEmpty;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     cnt_q   <= '0;
                  end
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

   for (genvar j = 0; j < LANES_OUT; j++) begin : g_lane
      logic signed [7:0] lane_sel;
      int16_t            lane_res;

      always_comb begin
         lane_sel = hold_data_q[8 * (32'(cnt_q) * LANES_OUT + j) +: 8];
      end

      dequant_lane #(
         .SHIFT_W (SHIFT_W)
      ) u_lane (
         .i_lane       (lane_sel),
`ifdef DEQUANT_ZERO_POINT_EN
         .i_zero_point (hold_zp_q),
`endif
         .i_shift_en   (hold_shift_en_q),
         .i_shift_num  (hold_shift_num_q),
         .o_result     (lane_res)
      );

      assign o_data[16*j +: 16] = lane_res;
   end

endmodule

// File: tb/tb_dequant_8b_16b.sv
// Self-checking bench for dequant_8b_16b against an integer-arithmetic reference model.
module tb_dequant_8b_16b;

   localparam int unsigned LI = 4;
   localparam int unsigned LO = 2;
   localparam int unsigned SW = 4;
   localparam int unsigned NB = LI / LO;

   typedef struct {
      logic [16*LO-1:0] data;
      logic             last;
   } beat_t;

   logic              clk;
   logic              rst;
   logic              valid;
   logic              in_ready;
   logic [8*LI-1:0]   data;
   logic              shift_en;
   logic [SW-1:0]     shift_num;
   logic [7:0]        zp;
   logic              out_valid;
   logic              out_ready;
   logic [16*LO-1:0]  odata;
   logic              last;

   int pass_cnt  = 0;
   int total_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dequant_8b_16b #(
      .LANES_IN  (LI),
      .LANES_OUT (LO),
      .SHIFT_W   (SW)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (valid),
      .o_in_ready   (in_ready),
      .i_data       (data),
      .i_shift_en   (shift_en),
      .i_shift_num  (shift_num),
`ifdef DEQUANT_ZERO_POINT_EN
      .i_zero_point (zp),
`endif
      .o_valid      (out_valid),
      .i_out_ready  (out_ready),
      .o_data       (odata),
      .o_last       (last)
   );

   // Reference: plain integer arithmetic on the lane value; zp stays 0 without the feature.
   function automatic logic [15:0] ref_lane(input logic [7:0] b, input logic en,
                                             input logic [SW-1:0] sh, input logic [7:0] z);
      longint v;
      v = longint'($signed(b)) - longint'($signed(z));
      if (en) v = v * (longint'(1) << sh);
      if (v > 32767) return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return 16'(v);
   endfunction

   function automatic logic [16*LO-1:0] ref_beat(input logic [8*LI-1:0] w, input logic en,
                                                 input logic [SW-1:0] sh, input logic [7:0] z,
                                                 input int b);
      logic [16*LO-1:0] r;
      for (int j = 0; j < int'(LO); j++) begin
         r[16*j +: 16] = ref_lane(w[8*(b*int'(LO)+j) +: 8], en, sh, z);
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [8*LI-1:0] w, input logic en,
                        input logic [SW-1:0] sh, input logic [7:0] z);
      valid     = v;
      data      = w;
      shift_en  = en;
      shift_num = sh;
      zp        = z;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      repeat (2) step();
      rst = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (last !== 1'b0) $display("FAIL reset_last: got %b want 0", last); else pass_cnt++;
      total_cnt++; if (odata !== '0) $display("FAIL reset_data: got %h want 0", odata); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_basic_word();
      logic [31:0] w;
      w = 32'h7F8001FF;
      drive(1'b1, w, 1'b0, 4'd5, 8'h00);
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_pre_valid: got %b want 0", out_valid); else pass_cnt++;
      step();
      drive(1'b0, 32'hDEADBEEF, 1'b1, 4'd3, 8'h00);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_latency: got %b want 1", out_valid); else pass_cnt++;
      total_cnt++; if (odata !== 32'h0001FFFF) $display("FAIL basic_beat0: got %h want 0001ffff", odata); else pass_cnt++;
      total_cnt++; if (last !== 1'b0) $display("FAIL basic_last0: got %b want 0", last); else pass_cnt++;
      step();
      total_cnt++; if (odata !== ref_beat(w, 1'b0, 4'd5, 8'h00, 1)) $display("FAIL basic_beat1: got %h want %h", odata, ref_beat(w, 1'b0, 4'd5, 8'h00, 1)); else pass_cnt++;
      total_cnt++; if (last !== 1'b1) $display("FAIL basic_last1: got %b want 1", last); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_shift_sat();
      logic [31:0]   w;
      logic [SW-1:0] sh;
      w = 32'h0000807F;
      for (int k = 8; k <= 9; k++) begin
         sh = SW'(k);
         drive(1'b1, w, 1'b1, sh, 8'h00);
         step();
         drive(1'b0, '0, 1'b0, '0, 8'h00);
         total_cnt++; if (odata !== ref_beat(w, 1'b1, sh, 8'h00, 0)) $display("FAIL shift%0d_beat0: got %h want %h", k, odata, ref_beat(w, 1'b1, sh, 8'h00, 0)); else pass_cnt++;
         step();
         total_cnt++; if (odata !== 32'h0) $display("FAIL shift%0d_beat1: got %h want 0", k, odata); else pass_cnt++;
         step();
      end
   endtask

   task automatic test_stall();
      logic [31:0]   w;
      logic          en;
      logic [SW-1:0] sh;
      w  = $urandom;
      en = 1'b1;
      sh = SW'($urandom_range(0, 15));
      out_ready = 1'b0;
      drive(1'b1, w, en, sh, 8'h00);
      step();
      drive(1'b1, ~w, 1'b0, ~sh, 8'h00);
      #1;
      for (int c = 0; c < 5; c++) begin
         total_cnt++; if (out_valid !== 1'b1 || odata !== ref_beat(w, en, sh, 8'h00, 0)) $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", c, out_valid, odata, ref_beat(w, en, sh, 8'h00, 0)); else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready%0d: got %b want 0", c, in_ready); else pass_cnt++;
         step();
      end
      out_ready = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      step();
      total_cnt++; if (odata !== ref_beat(w, en, sh, 8'h00, 1) || last !== 1'b1) $display("FAIL stall_beat1: got %h last=%b want %h last=1", odata, last, ref_beat(w, en, sh, 8'h00, 1)); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0]   bw[4];
      logic          be[4];
      logic [SW-1:0] bs[4];
      int            nxt;
      for (int i = 0; i < 4; i++) begin
         bw[i] = $urandom;
         be[i] = 1'($urandom_range(0, 1));
         bs[i] = SW'($urandom_range(0, 15));
      end
      out_ready = 1'b1;
      drive(1'b1, bw[0], be[0], bs[0], 8'h00);
      step();
      nxt = 1;
      drive(1'b1, bw[1], be[1], bs[1], 8'h00);
      #1;
      for (int k = 0; k < 8; k++) begin
         total_cnt++;
         if (out_valid !== 1'b1 || odata !== ref_beat(bw[k/2], be[k/2], bs[k/2], 8'h00, k % 2) || last !== 1'(k % 2))
            $display("FAIL b2b_beat%0d: got v=%b %h last=%b want v=1 %h last=%0d", k, out_valid, odata, last, ref_beat(bw[k/2], be[k/2], bs[k/2], 8'h00, k % 2), k % 2);
         else pass_cnt++;
         total_cnt++; if (in_ready !== 1'(k % 2)) $display("FAIL b2b_in_ready%0d: got %b want %0d", k, in_ready, k % 2); else pass_cnt++;
         step();
         if (k % 2 == 1) begin
            nxt++;
            if (nxt < 4) drive(1'b1, bw[nxt], be[nxt], bs[nxt], 8'h00);
            else drive(1'b0, '0, 1'b0, '0, 8'h00);
         end
      end
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_reset_mid_word();
      logic [31:0] w1, w2;
      w1 = $urandom;
      w2 = $urandom;
      out_ready = 1'b1;
      drive(1'b1, w1, 1'b0, '0, 8'h00);
      step();
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL rstmid_pre: got %b want 1", out_valid); else pass_cnt++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total_cnt++; if (out_valid !== 1'b0 || last !== 1'b0 || odata !== '0) $display("FAIL rstmid_state: got v=%b last=%b %h want 0 0 0", out_valid, last, odata); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else pass_cnt++;
      drive(1'b1, w2, 1'b1, 4'd2, 8'h00);
      step();
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      total_cnt++; if (odata !== ref_beat(w2, 1'b1, 4'd2, 8'h00, 0) || last !== 1'b0) $display("FAIL rstmid_beat0: got %h last=%b want %h last=0", odata, last, ref_beat(w2, 1'b1, 4'd2, 8'h00, 0)); else pass_cnt++;
      step();
      total_cnt++; if (odata !== ref_beat(w2, 1'b1, 4'd2, 8'h00, 1) || last !== 1'b1) $display("FAIL rstmid_beat1: got %h last=%b want %h last=1", odata, last, ref_beat(w2, 1'b1, 4'd2, 8'h00, 1)); else pass_cnt++;
      step();
   endtask

`ifdef DEQUANT_ZERO_POINT_EN
   task automatic test_zero_point();
      out_ready = 1'b1;
      drive(1'b1, 32'h00000005, 1'b1, 4'd2, 8'hFB);
      step();
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      total_cnt++; if (odata[15:0] !== 16'd40) $display("FAIL zp_pos: got %h want 0028", odata[15:0]); else pass_cnt++;
      repeat (2) step();
      drive(1'b1, 32'h00000080, 1'b1, 4'd15, 8'h7F);
      step();
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      total_cnt++; if (odata[15:0] !== 16'h8000) $display("FAIL zp_sat: got %h want 8000", odata[15:0]); else pass_cnt++;
      repeat (2) step();
   endtask
`endif

   task automatic test_random();
      beat_t  q[$];
      beat_t  exp;
      int     sent;
      int     cycles;
      logic   acc;
      logic   xf;
      sent   = 0;
      cycles = 0;
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      while ((sent < 24 || q.size() > 0 || out_valid) && cycles < 3000) begin
         if (!valid && sent < 24 && $urandom_range(0, 3) != 0) begin
            drive(1'b1, $urandom, 1'($urandom_range(0, 1)), SW'($urandom_range(0, 15)), 8'h00);
`ifdef DEQUANT_ZERO_POINT_EN
            zp = 8'($urandom);
`endif
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid) begin
            total_cnt++;
            if (q.size() == 0) begin
               $display("FAIL rand_unexpected: got beat %h want none", odata);
            end else begin
               exp = q[0];
               if (odata !== exp.data || last !== exp.last)
                  $display("FAIL rand_beat: got %h last=%b want %h last=%b", odata, last, exp.data, exp.last);
               else pass_cnt++;
            end
         end
         acc = valid && in_ready;
         xf  = out_valid && out_ready;
         if (xf && q.size() > 0) void'(q.pop_front());
         @(posedge clk);
         #1;
         if (acc) begin
            for (int b = 0; b < int'(NB); b++) begin
               exp.data = ref_beat(data, shift_en, shift_num, zp, b);
               exp.last = (b == int'(NB) - 1);
               q.push_back(exp);
            end
            sent++;
            valid = 1'b0;
         end
         cycles++;
      end
      total_cnt++; if (sent != 24 || q.size() != 0) $display("FAIL rand_complete: got sent=%0d pending=%0d want 24 0", sent, q.size()); else pass_cnt++;
      drive(1'b0, '0, 1'b0, '0, 8'h00);
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 8'h00);
      test_reset();
      test_basic_word();
      test_shift_sat();
      test_stall();
      test_back_to_back();
      test_reset_mid_word();
`ifdef DEQUANT_ZERO_POINT_EN
      test_zero_point();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
